// File: rtl/warp_scheduler_pkg.sv
// Shared types and sizing for the warp scheduler, its arbiter and the program store.
package warp_scheduler_pkg;

  localparam int unsigned NUM_WARPS = 4;
  localparam int unsigned PC_W      = 4;
  localparam int unsigned WARP_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned CNT_W     = PC_W + 1;

  typedef enum logic [1:0] {
    WarpIdle     = 2'd0,
    WarpReady    = 2'd1,
    WarpIssued   = 2'd2,
    WarpCooldown = 2'd3
  } warp_state_e;

  function automatic logic [WARP_W-1:0] onehot_idx(input logic [NUM_WARPS-1:0] oh);
    logic [WARP_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (oh[i]) idx = WARP_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins, one-hot grant.
module warp_scheduler_rr_arbiter
  import warp_scheduler_pkg::*;
(
  input  logic [NUM_WARPS-1:0] req_i,
  input  logic [WARP_W-1:0]    ptr_i,
  output logic [NUM_WARPS-1:0] gnt_o
);

  logic [WARP_W-1:0] idx;
  logic              found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_WARPS; k++) begin
      // NUM_WARPS is a power of two, so the index wraps naturally.
      idx = ptr_i + WARP_W'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp instruction issue scheduler: per-warp pc/count, round-robin issue slot,
// one-cycle cooldown between issues of the same warp, two-deep done queue.
module warp_scheduler
  import warp_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_valid_i,
  output logic              launch_ready_o,
  input  logic [WARP_W-1:0] launch_warp_i,
  input  logic [PC_W-1:0]   launch_pc_i,
  input  logic [CNT_W-1:0]  launch_count_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [WARP_W-1:0] issue_warp_o,
  output logic [PC_W-1:0]   issue_pc_o,
  output logic              done_valid_o,
  output logic [WARP_W-1:0] done_warp_o,
  output logic              busy_o
);

  warp_state_e      state_q [NUM_WARPS];
  warp_state_e      state_d [NUM_WARPS];
  logic [PC_W-1:0]  pc_q    [NUM_WARPS];
  logic [PC_W-1:0]  pc_d    [NUM_WARPS];
  logic [CNT_W-1:0] rem_q   [NUM_WARPS];
  logic [CNT_W-1:0] rem_d   [NUM_WARPS];

  logic              issue_valid_q, issue_valid_d;
  logic [WARP_W-1:0] issue_warp_q, issue_warp_d;
  logic [PC_W-1:0]   issue_pc_q, issue_pc_d;
  logic [WARP_W-1:0] ptr_q, ptr_d;
  logic              done_valid_q, done_valid_d;
  logic [WARP_W-1:0] done_warp_q, done_warp_d;
  logic              pend_valid_q, pend_valid_d;
  logic [WARP_W-1:0] pend_warp_q, pend_warp_d;

  logic [NUM_WARPS-1:0] req, gnt;
  logic [WARP_W-1:0]    gnt_idx;
  logic launch_zero, launch_fire, zero_fire, accept, load, acc_done;

  warp_scheduler_rr_arbiter u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      // A cooling-down warp may be reloaded on the edge that ends its gap cycle.
      req[i] = (state_q[i] == WarpReady) || (state_q[i] == WarpCooldown);
    end
    gnt_idx     = onehot_idx(gnt);
    launch_zero = (launch_count_i == '0);
    // A zero-count launch is held off while a done is still queued, so no done is lost.
    launch_ready_o = (state_q[launch_warp_i] == WarpIdle) && !(launch_zero && pend_valid_q);
    launch_fire = launch_valid_i && launch_ready_o;
    zero_fire   = launch_fire && launch_zero;
    accept      = issue_valid_q && issue_ready_i;
    load        = (!issue_valid_q || issue_ready_i) && (|req);
    acc_done    = accept && (rem_q[issue_warp_q] == CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (state_q[i] == WarpCooldown) state_d[i] = WarpReady;
      if (accept && issue_warp_q == WARP_W'(i)) begin
        pc_d[i]    = pc_q[i] + PC_W'(1);
        rem_d[i]   = rem_q[i] - CNT_W'(1);
        state_d[i] = (rem_q[i] == CNT_W'(1)) ? WarpIdle : WarpCooldown;
      end
      if (load && gnt[i]) state_d[i] = WarpIssued;
      if (launch_fire && !launch_zero && launch_warp_i == WARP_W'(i)) begin
        pc_d[i]    = launch_pc_i;
        rem_d[i]   = launch_count_i;
        state_d[i] = WarpReady;
      end
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_pc_d    = issue_pc_q;
    ptr_d         = ptr_q;
    if (load) begin
      issue_valid_d = 1'b1;
      issue_warp_d  = gnt_idx;
      issue_pc_d    = pc_q[gnt_idx];
      ptr_d         = gnt_idx + WARP_W'(1);
    end else if (accept) begin
      issue_valid_d = 1'b0;
    end
  end

  // Oldest first: queued done, then accept-done, then zero-count launch.
  always_comb begin
    done_valid_d = 1'b0;
    done_warp_d  = done_warp_q;
    pend_valid_d = 1'b0;
    pend_warp_d  = pend_warp_q;
    if (pend_valid_q) begin
      done_valid_d = 1'b1;
      done_warp_d  = pend_warp_q;
      if (acc_done) begin
        pend_valid_d = 1'b1;
        pend_warp_d  = issue_warp_q;
      end
    end else if (acc_done) begin
      done_valid_d = 1'b1;
      done_warp_d  = issue_warp_q;
      if (zero_fire) begin
        pend_valid_d = 1'b1;
        pend_warp_d  = launch_warp_i;
      end
    end else if (zero_fire) begin
      done_valid_d = 1'b1;
      done_warp_d  = launch_warp_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= WarpIdle;
        pc_q[i]    <= '0;
        rem_q[i]   <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_pc_q    <= '0;
      ptr_q         <= '0;
      done_valid_q  <= 1'b0;
      done_warp_q   <= '0;
      pend_valid_q  <= 1'b0;
      pend_warp_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rem_q         <= rem_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_pc_q    <= issue_pc_d;
      ptr_q         <= ptr_d;
      done_valid_q  <= done_valid_d;
      done_warp_q   <= done_warp_d;
      pend_valid_q  <= pend_valid_d;
      pend_warp_q   <= pend_warp_d;
    end
  end

  always_comb begin
    busy_o = issue_valid_q;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      busy_o = busy_o | (state_q[i] != WarpIdle);
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_warp_o  = issue_warp_q;
  assign issue_pc_o    = issue_pc_q;
  assign done_valid_o  = done_valid_q;
  assign done_warp_o   = done_warp_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              launch_valid;
  logic              launch_ready;
  logic [WARP_W-1:0] launch_warp;
  logic [PC_W-1:0]   launch_pc;
  logic [CNT_W-1:0]  launch_count;
  logic              issue_valid;
  logic              issue_ready;
  logic [WARP_W-1:0] issue_warp;
  logic [PC_W-1:0]   issue_pc;
  logic              done_valid;
  logic [WARP_W-1:0] done_warp;
  logic              busy;

  always #5 clk = ~clk;

  warp_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .launch_valid_i (launch_valid),
    .launch_ready_o (launch_ready),
    .launch_warp_i  (launch_warp),
    .launch_pc_i    (launch_pc),
    .launch_count_i (launch_count),
    .issue_valid_o  (issue_valid),
    .issue_ready_i  (issue_ready),
    .issue_warp_o   (issue_warp),
    .issue_pc_o     (issue_pc),
    .done_valid_o   (done_valid),
    .done_warp_o    (done_warp),
    .busy_o         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a warp is "active" from launch until its last instruction is accepted; it may be
  // picked once it is out of the issue slot and the edge after its launch/accept has come.
  bit m_active [NUM_WARPS];
  int m_pc     [NUM_WARPS];
  int m_rem    [NUM_WARPS];
  int m_elig   [NUM_WARPS];
  bit m_sv;
  int m_sw, m_spc, m_ptr, m_dw, edge_n;
  bit m_dv;
  int m_q[$];

  int acc_pcs[$];
  int acc_warps[$];
  int done_warps[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_WARPS; i++) begin
      m_active[i] = 1'b0;
      m_pc[i]     = 0;
      m_rem[i]    = 0;
      m_elig[i]   = 0;
    end
    m_sv  = 1'b0;
    m_sw  = 0;
    m_spc = 0;
    m_ptr = 0;
    m_dv  = 1'b0;
    m_dw  = 0;
    m_q.delete();
  endfunction

  function automatic bit model_launch_ready(input int w, input int cnt);
    return !m_active[w] && !(cnt == 0 && m_q.size() != 0);
  endfunction

  function automatic void model_edge(input bit xfer, input int w, input int pc, input int cnt,
                                     input bit ir);
    int pick;
    bit acc;
    pick = -1;
    acc  = m_sv && ir;
    if (!m_sv || ir) begin
      for (int k = 0; k < NUM_WARPS; k++) begin
        int c;
        c = (m_ptr + k) % NUM_WARPS;
        if (pick < 0 && m_active[c] && !(m_sv && m_sw == c) && m_elig[c] <= edge_n) pick = c;
      end
    end
    if (acc) begin
      m_pc[m_sw]  = (m_pc[m_sw] + 1) % (1 << PC_W);
      m_rem[m_sw] = m_rem[m_sw] - 1;
      if (m_rem[m_sw] == 0) begin
        m_active[m_sw] = 1'b0;
        m_q.push_back(m_sw);
      end else begin
        m_elig[m_sw] = edge_n + 1;
      end
    end
    if (xfer) begin
      if (cnt == 0) m_q.push_back(w);
      else begin
        m_active[w] = 1'b1;
        m_pc[w]     = pc;
        m_rem[w]    = cnt;
        m_elig[w]   = edge_n + 1;
      end
    end
    if (pick >= 0) begin
      m_sv  = 1'b1;
      m_sw  = pick;
      m_spc = m_pc[pick];
      m_ptr = (pick + 1) % NUM_WARPS;
    end else if (acc) begin
      m_sv = 1'b0;
    end
    if (m_q.size() != 0) begin
      m_dv = 1'b1;
      m_dw = m_q.pop_front();
    end else begin
      m_dv = 1'b0;
    end
    edge_n++;
  endfunction

  task automatic check_outputs();
    bit any;
    any = m_sv;
    for (int i = 0; i < NUM_WARPS; i++) any |= m_active[i];
    check_eq("issue_valid", issue_valid, m_sv);
    check_eq("issue_warp", issue_warp, m_sw);
    check_eq("issue_pc", issue_pc, m_spc);
    check_eq("done_valid", done_valid, m_dv);
    check_eq("done_warp", done_warp, m_dw);
    check_eq("busy", busy, any);
  endtask

  task automatic step(input bit rs, input bit lv, input int lw, input int lpc, input int lcnt,
                      input bit ir);
    bit mr;
    @(negedge clk);
    rst          = rs;
    launch_valid = lv;
    launch_warp  = WARP_W'(lw);
    launch_pc    = PC_W'(lpc);
    launch_count = CNT_W'(lcnt);
    issue_ready  = ir;
    #1;
    mr = model_launch_ready(lw, lcnt);
    if (!rs) begin
      check_eq("launch_ready", launch_ready, mr);
      if (issue_valid && ir) begin
        acc_pcs.push_back(int'(issue_pc));
        acc_warps.push_back(int'(issue_warp));
      end
      model_edge(lv && mr, lw, lpc, lcnt, ir);
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (done_valid) done_warps.push_back(int'(done_warp));
  endtask

  task automatic idle(input int n, input bit ir);
    repeat (n) step(1'b0, 1'b0, 0, 0, 1, ir);
  endtask

  task automatic clear_logs();
    acc_pcs.delete();
    acc_warps.delete();
    done_warps.delete();
  endtask

  task automatic check_pcs(input string tag, input int start, input int n);
    check_eq({tag, "_len"}, acc_pcs.size(), n);
    for (int i = 0; i < n && i < acc_pcs.size(); i++) begin
      check_eq(tag, acc_pcs[i], (start + i) % (1 << PC_W));
    end
  endtask

  initial begin
    rst = 1'b1; launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; launch_count = '0;
    issue_ready = 1'b0; edge_n = 0;
    model_reset();
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_issue_valid", issue_valid, 0);

    // Single warp: every other cycle, then one done.
    clear_logs();
    step(1'b0, 1'b1, 0, 3, 4, 1'b1);
    idle(12, 1'b1);
    check_pcs("single_pc", 3, 4);
    check_eq("single_done_n", done_warps.size(), 1);
    if (done_warps.size() > 0) check_eq("single_done_w", done_warps[0], 0);

    // Four warps back to back.
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    clear_logs();
    for (int w = 0; w < NUM_WARPS; w++) step(1'b0, 1'b1, w, 0, 2, 1'b1);
    idle(12, 1'b1);
    check_eq("rr_len", acc_warps.size(), 2 * NUM_WARPS);
    for (int i = 0; i < 2 * NUM_WARPS && i < acc_warps.size(); i++)
      check_eq("rr_warp", acc_warps[i], i % NUM_WARPS);
    check_eq("rr_done_n", done_warps.size(), NUM_WARPS);
    for (int i = 0; i < NUM_WARPS && i < done_warps.size(); i++)
      check_eq("rr_done_w", done_warps[i], i);

    // PC wrap.
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    clear_logs();
    step(1'b0, 1'b1, 1, 14, 4, 1'b1);
    idle(12, 1'b1);
    check_pcs("wrap_pc", 14, 4);

    // Stall: slot holds for five cycles, no pc advance.
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    clear_logs();
    step(1'b0, 1'b1, 0, 5, 3, 1'b0);
    idle(6, 1'b0);
    check_eq("stall_valid", issue_valid, 1);
    check_eq("stall_pc", issue_pc, 5);
    check_eq("stall_accepts", acc_pcs.size(), 0);
    idle(10, 1'b1);
    check_pcs("stall_pc_seq", 5, 3);

    // Zero-count launch.
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    clear_logs();
    step(1'b0, 1'b1, 2, 7, 0, 1'b1);
    check_eq("zero_done_v", done_valid, 1);
    check_eq("zero_done_w", done_warp, 2);
    idle(5, 1'b1);
    check_eq("zero_issues", acc_warps.size(), 0);
    check_eq("zero_done_n", done_warps.size(), 1);

    // Reset mid-run.
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    for (int w = 0; w < 3; w++) step(1'b0, 1'b1, w, 4 * w, 8, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1);
    check_eq("abort_valid", issue_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done_valid, 0);
    check_eq("abort_pc", issue_pc, 0);
    clear_logs();
    idle(3, 1'b1);
    check_eq("abort_no_done", done_warps.size(), 0);
    step(1'b0, 1'b1, 3, 9, 1, 1'b1);
    idle(5, 1'b1);
    check_eq("relaunch_done_n", done_warps.size(), 1);
    if (done_warps.size() > 0) check_eq("relaunch_done_w", done_warps[0], 3);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int cnt;
      cnt = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 16);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
           $urandom_range(0, NUM_WARPS - 1), $urandom_range(0, (1 << PC_W) - 1), cnt,
           ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter: NUM_WARPS, 4, number of independent shader contexts (power of two, 2..8).
REQ-002 Parameter: PC_W, 4, program-counter width (16-entry program store).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: launch_valid  input  1  request to start a warp.
REQ-006 Port: launch_ready  output  1  high when slot launch_warp is IDLE.
REQ-007 Port: launch_warp  input  log2(NUM_WARPS)  target warp slot.
REQ-008 Port: launch_pc  input  PC_W  first instruction address.
REQ-009 Port: launch_count  input  PC_W+1  instructions to run, 0..16.
REQ-010 Port: issue_valid  output  1  registered issue slot holds a warp/instruction.
REQ-011 Port: issue_ready  input  1  datapath accepts the issue slot this cycle.
REQ-012 Port: issue_warp  output  log2(NUM_WARPS)  warp being issued.
REQ-013 Port: issue_pc  output  PC_W  instruction address for the program store.
REQ-014 Port: done_valid  output  1  one-cycle pulse, a warp finished.
REQ-015 Port: done_warp  output  log2(NUM_WARPS)  warp that finished.
REQ-016 Port: busy  output  1  OR of all warps not IDLE or issue_valid high.

Function
REQ-017 Per-warp state: IDLE, READY, ISSUED, COOLDOWN; per-warp pc (PC_W) and remaining count (PC_W+1).
REQ-018 Launch transfer = launch_valid & launch_ready; slot loads pc=launch_pc, remaining=launch_count, goes READY next cycle.
REQ-019 Launch with launch_count=0: slot stays IDLE, done_valid/done_warp pulse the following cycle, nothing issued.
REQ-020 Issue slot loads on a clock edge when (!issue_valid | issue_ready) and at least one warp is READY; chosen warp goes ISSUED.
REQ-021 Selection: round-robin over READY warps, search starts at warp after last loaded warp; pointer resets to warp 0 first.
REQ-022 issue_valid, issue_warp, issue_pc hold stable while issue_valid & !issue_ready.
REQ-023 Accept (issue_valid & issue_ready): warp pc increments mod 2^PC_W (15 wraps to 0), remaining decrements.
REQ-024 Accept with remaining reaching 0: warp goes IDLE; done_valid pulses next cycle with done_warp.
REQ-025 Accept with remaining > 0: warp goes COOLDOWN one cycle, then READY (enforces one-cycle writeback gap, no back-to-back issue of one warp).
REQ-026 Accept and reload in the same edge allowed; if no READY warp, issue_valid drops.
REQ-027 Earliest latency: launch edge N -> READY after N -> issue_valid high after edge N+1.
REQ-028 Single warp sustained rate: one issue per two cycles; two or more warps: one issue per cycle with issue_ready held high.
REQ-029 Simultaneous launch_count=0 done and accept-done in one cycle: accept-done reported first, zero-count done on the next cycle (done queue depth 2); no done event lost.
REQ-030 launch_ready never depends on issue_ready; launch to a slot completing in the same cycle is refused (ready low until IDLE visible).

Reset
REQ-031 On rst: all warps IDLE, pc and remaining 0, issue_valid 0, issue_warp 0, issue_pc 0, done_valid 0, done_warp 0, busy 0, round-robin pointer 0.
REQ-032 rst mid-program aborts all warps with no done pulse; in-flight issue slot discarded.

Structure
REQ-033 Shared package holds warp-state enum, NUM_WARPS, PC_W, and warp-index width constant, reused by pipeline and program store.
REQ-034 One sub-module: rr_arbiter (NUM_WARPS request vector, pointer in, one-hot grant out), combinational.

Verification
REQ-035 Launch warp 0, pc=3, count=4; issue_ready=1 -> issue_pc 3,4,5,6 on every other cycle, then done_warp=0 pulse once.
REQ-036 Launch warps 0..3, pc=0, count=2 each -> issue_warp 0,1,2,3,0,1,2,3 back-to-back, four done pulses.
REQ-037 Warp 1 pc=14 count=4 -> issue_pc 14,15,0,1.
REQ-038 issue_ready low 5 cycles with issue_valid high -> issue_warp/issue_pc unchanged, no pc advance, no extra issue.
REQ-039 launch_count=0 on warp 2 -> done_warp=2 next cycle, issue_valid never high for warp 2.
REQ-040 rst asserted mid-run with 3 warps active -> all outputs 0 next cycle, no done pulse, new launch accepted afterwards.
